// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART deserializer and the keyboard-register read path.
// First-word-fall-through head, per-byte framing flag, sticky overflow and RTS/CTS hysteresis.
module uart_rx_fifo #(
    parameter int ADDR_W     = 4,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              wr_ferr,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_ferr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              uart_cts
);

    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] HIGH_C  = (ADDR_W + 1)'(HIGH_WATER);
    localparam logic [ADDR_W:0] LOW_C   = (ADDR_W + 1)'(LOW_WATER);
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE_C = {{(ADDR_W - 1){1'b0}}, 1'b1};

    logic [8:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_nxt_s;
    logic              overflow_r;
    logic              ovf_nxt_s;
    logic              cts_r;
    logic              cts_nxt_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              drop_s;

    // Accept/drop decisions and next-state for occupancy, overflow and CTS.
    always_comb begin
        rd_acc_s = rd_en && (count_r != ZERO_C);
        // A pop in the same cycle frees a slot, so a full buffer still takes the byte.
        wr_acc_s = wr_valid && ((count_r < DEPTH_C) || rd_acc_s);
        drop_s   = wr_valid && !wr_acc_s;

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase

        if (count_nxt_s >= HIGH_C) begin
            cts_nxt_s = 1'b1;
        end else if (count_nxt_s <= LOW_C) begin
            cts_nxt_s = 1'b0;
        end else begin
            cts_nxt_s = cts_r;
        end

        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = overflow_r;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= {wr_ferr, wr_data};
        end
    end

    // Pointers, occupancy, overflow flag and flow-control pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= ZERO_C;
            overflow_r <= 1'b0;
            cts_r      <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r    <= count_nxt_s;
            overflow_r <= ovf_nxt_s;
            cts_r      <= cts_nxt_s;
        end
    end

    // Head presentation and status decode from the count register.
    always_comb begin
        empty    = (count_r == ZERO_C);
        full     = (count_r == DEPTH_C);
        count    = count_r;
        overflow = overflow_r;
        uart_cts = cts_r;
        if (empty) begin
            rd_data = 8'h00;
            rd_ferr = 1'b0;
        end else begin
            rd_data = mem_r[rd_ptr_r][7:0];
            rd_ferr = mem_r[rd_ptr_r][8];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected head entries, a monitor checks every pop.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ferr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_ferr;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic       uart_cts;

    int         checks = 0;
    int         errors = 0;
    int         mcount = 0;
    logic [8:0] exp_q[$];

    uart_rx_fifo #(.ADDR_W(4), .HIGH_WATER(12), .LOW_WATER(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ferr  (wr_ferr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_ferr  (rd_ferr),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .uart_cts (uart_cts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: whenever the DUT hands out a byte, compare it with the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_en === 1'b1 && empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h expected=none", {rd_ferr, rd_data});
            end else begin
                chk("pop_head", {23'd0, rd_ferr, rd_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock cycle of stimulus; queues expected bytes for writes the buffer will take.
    task automatic cyc(input logic wv, input logic [7:0] wd, input logic wf,
                       input logic re, input logic co);
        bit racc;
        bit wacc;
        wr_valid = wv;
        wr_data  = wd;
        wr_ferr  = wf;
        rd_en    = re;
        clr_ovf  = co;
        racc = re && (mcount > 0);
        wacc = wv && ((mcount < 16) || racc);
        if (wacc) exp_q.push_back({wf, wd});
        if (wacc && !racc) mcount++;
        else if (racc && !wacc) mcount--;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        wr_ferr  = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_ferr = 1'b0;
        rd_en = 1'b0; clr_ovf = 1'b0;
        #2;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_cts", {31'd0, uart_cts}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'h00);
        @(posedge clk); #1; rst = 1'b1;

        // Read while empty is ignored
        pop();
        chk("idle_rd_count", {27'd0, count}, 32'd0);
        chk("idle_rd_empty", {31'd0, empty}, 32'd1);

        // Single byte, visible one edge after the write
        cyc(1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
        chk("one_empty", {31'd0, empty}, 32'd0);
        chk("one_count", {27'd0, count}, 32'd1);
        chk("one_data", {24'd0, rd_data}, 32'h2A);
        pop();
        chk("one_pop_empty", {31'd0, empty}, 32'd1);

        // Empty with write+read: write wins, read ignored
        cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        chk("empty_wr_rd_count", {27'd0, count}, 32'd1);
        pop();

        // Framing flag and ordering
        cyc(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h8D, 1'b0, 1'b0, 1'b0);
        chk("ferr_head", {31'd0, rd_ferr}, 32'd1);
        pop();
        chk("ferr_second", {31'd0, rd_ferr}, 32'd0);
        chk("data_second", {24'd0, rd_data}, 32'h8D);
        pop();

        // Fill to high water, then drain through the hysteresis band
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 10) chk("cts_at_11", {31'd0, uart_cts}, 32'd0);
        end
        chk("cts_at_12", {31'd0, uart_cts}, 32'd1);
        chk("count_12", {27'd0, count}, 32'd12);
        for (int i = 0; i < 7; i++) pop();
        chk("count_5", {27'd0, count}, 32'd5);
        chk("cts_at_5", {31'd0, uart_cts}, 32'd1);
        pop();
        chk("count_4", {27'd0, count}, 32'd4);
        chk("cts_at_4", {31'd0, uart_cts}, 32'd0);

        // Refill across the pointer wrap to full
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_cts", {31'd0, uart_cts}, 32'd1);

        // Overflow: dropped byte, head untouched, set beats clear
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {27'd0, count}, 32'd16);
        chk("ovf_head", {24'd0, rd_data}, 32'h08);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear", {31'd0, overflow}, 32'd0);

        // Full with simultaneous read and write
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("full_rw_count", {27'd0, count}, 32'd16);
        chk("full_rw_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) pop();
        chk("pre_rst_count", {27'd0, count}, 32'd11);
        chk("pre_rst_cts", {31'd0, uart_cts}, 32'd1);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk); #3; rst = 1'b0;
        #1;
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_cts", {31'd0, uart_cts}, 32'd0);
        chk("mid_rst_data", {24'd0, rd_data}, 32'h00);
        exp_q.delete();
        mcount = 0;
        @(posedge clk); #1; rst = 1'b1;

        // Operation resumes cleanly after reset
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("post_rst_ferr", {31'd0, rd_ferr}, 32'd1);
        chk("post_rst_count", {27'd0, count}, 32'd1);
        pop();
        chk("end_empty", {31'd0, empty}, 32'd1);
        chk("end_queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the UART receiver's byte deserializer and the Apple-1 keyboard-register read path.
- Stores received bytes and their per-byte framing-error flag.
- Presents the oldest byte first-word-fall-through.
- Drives the RTS/CTS flow-control pin with hysteresis so the host pauses before the buffer overflows.

Parameters:
- ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W entries (16).
- HIGH_WATER, 12, occupancy at or above which uart_cts is deasserted.
- LOW_WATER, 4, occupancy at or below which uart_cts is reasserted; LOW_WATER < HIGH_WATER <= DEPTH.

Ports:
- clk  input  1  system clock (25 MHz in the Apple-1 build).
- rst  input  1  asynchronous, active-low reset.
- wr_valid  input  1  one-cycle strobe from the deserializer: byte complete.
- wr_data  input  8  received byte, valid with wr_valid.
- wr_ferr  input  1  stop-bit framing error for this byte, valid with wr_valid.
- rd_en  input  1  pop the head entry (one cycle per byte).
- rd_data  output  8  head byte, combinational from storage; 8'h00 when empty.
- rd_ferr  output  1  framing-error flag of the head entry; 0 when empty.
- empty  output  1  no entries; the register interface uses !empty as its "key ready" bit.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a byte was dropped because the buffer was full.
- clr_ovf  input  1  clears overflow.
- uart_cts  output  1  active-low clear-to-send to the host; 0 = host may transmit.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, uart_cts=0 (clear to send).
  - empty=1, full=0, rd_data=8'h00, rd_ferr=0.
  - Storage contents need not be reset.
  - Reset mid-operation discards all entries immediately; no partial state survives.
- Storage: DEPTH x 9 bits {ferr, data}.
  - ADDR_W-bit pointers wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked by a separate count register, not by pointer compare.
- Write accepted when wr_valid=1 and (count<DEPTH, or a read is accepted in the same cycle).
  - Stores {wr_ferr, wr_data} at wr_ptr; wr_ptr+1.
- Read accepted when rd_en=1 and count>0; rd_ptr+1.
  - rd_en while empty is ignored; pointers and count are unchanged.
- Count update per cycle: +1 for write only, -1 for read only, unchanged when both or neither are accepted.
- Simultaneous events:
  - Full with write+read: both accepted, count stays DEPTH.
  - Empty with write+read: write accepted, read ignored, count becomes 1.
- FWFT: a byte written in cycle N appears on rd_data, and empty falls, after the clock edge ending cycle N. Latency is 1 cycle.
- Overflow:
  - wr_valid=1, count==DEPTH and no accepted read: the byte is dropped, storage is untouched, overflow is set on the next edge.
  - clr_ovf=1 clears overflow.
  - If a drop and clr_ovf occur in the same cycle, set wins (overflow=1).
- Flow control:
  - uart_cts registered, updated from the post-update count.
  - Goes to 1 when next count >= HIGH_WATER.
  - Returns to 0 when next count <= LOW_WATER.
  - Otherwise holds its value (hysteresis band).
  - Changes are visible one edge after the causing write or read.
- full and empty are derived combinationally from the count register.

Test Plan:
- Reset then idle: after rst release, empty=1, count=0, uart_cts=0, overflow=0, rd_data=8'h00; rd_en pulse while empty leaves count=0.
- Single byte: wr_valid with wr_data=8'h2A, wr_ferr=0 -> next cycle empty=0, count=1, rd_data=8'h2A; rd_en -> empty=1, count=0.
- Framing flag plus ordering:
  - Write 8'hC1 (ferr=1) then 8'h8D (ferr=0).
  - Head reads 8'hC1, rd_ferr=1; after pop, head is 8'h8D, rd_ferr=0.
- Fill, hysteresis and wrap:
  - Write 12 bytes 8'h00..8'h0B -> uart_cts=1 one cycle after the 12th write.
  - Pop 7 -> count=5, uart_cts still 1; pop 1 more -> count=4, uart_cts=0.
  - Write 12 more; all 16 then pop in order with pointers wrapped.
- Overflow:
  - Fill to 16, write 8'hFF without rd_en -> byte dropped, overflow=1, count=16; the head byte is still the oldest.
  - clr_ovf together with another dropped write -> overflow stays 1; clr_ovf alone -> overflow=0.
- Full simultaneous read/write plus mid-operation reset:
  - At count=16, rd_en with wr_valid=8'h55 -> count stays 16, 8'h55 appears at the tail.
  - Assert rst mid-stream -> count=0, empty=1, uart_cts=0 immediately, without waiting for a clock edge.
